// File: rtl/fifo_rd_ptr_ctrl_if.sv
// Read-side bundle of the dual-clock FIFO: consumer request, synchronized
// write pointer in, and the read pointer, RAM controls and status out.
interface fifo_rd_ptr_ctrl_if #(
    parameter int unsigned ADDRWIDTH = 3
);
    localparam int unsigned PW = ADDRWIDTH + 1;

    logic                 re;
    logic [PW-1:0]        wptr_gray_sync;
    logic [PW-1:0]        rptr_gray;
    logic [ADDRWIDTH-1:0] raddr;
    logic                 mem_re;
    logic                 dvld;
    logic                 empty;
    logic                 almost_empty;
    logic [PW-1:0]        rd_count;
    logic                 underflow;

    // Controller side
    modport slave (
        input  re,
        input  wptr_gray_sync,
        output rptr_gray,
        output raddr,
        output mem_re,
        output dvld,
        output empty,
        output almost_empty,
        output rd_count,
        output underflow
    );

    // Consumer / environment side
    modport master (
        output re,
        output wptr_gray_sync,
        input  rptr_gray,
        input  raddr,
        input  mem_re,
        input  dvld,
        input  empty,
        input  almost_empty,
        input  rd_count,
        input  underflow
    );
endinterface

// File: rtl/fifo_rd_ptr_ctrl.sv
// Read-domain pointer and flag controller for the dual-clock FIFO: keeps the
// binary/Gray read pointer pair and derives empty, count and status flags.
module fifo_rd_ptr_ctrl #(
    parameter int unsigned ADDRWIDTH = 3,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              aresetn,
    fifo_rd_ptr_ctrl_if.slave bus
);
    localparam int unsigned PW = ADDRWIDTH + 1;

    logic [PW-1:0] r_rbin;
    logic [PW-1:0] r_rptr_gray;
    logic          r_empty;
    logic          r_almost_empty;
    logic [PW-1:0] r_rd_count;
    logic          r_dvld;
    logic          r_underflow;

    logic          w_rd_fire;
    logic [PW-1:0] w_rbin_next;
    logic [PW-1:0] w_rgray_next;
    logic [PW-1:0] w_wbin;
    logic [PW-1:0] w_diff;

    // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b = '0;
        for (int i = 0; i < int'(PW); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    // Next-pointer and occupancy arithmetic
    always_comb begin
        w_rd_fire    = bus.re & ~r_empty;
        w_rbin_next  = r_rbin + PW'(w_rd_fire);
        w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
        w_wbin       = gray2bin(bus.wptr_gray_sync);
        w_diff       = w_wbin - w_rbin_next;
    end

    // Pointer pair and registered status; empty compares Gray codes so the
    // extra MSB separates full from empty across the wrap.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_rbin         <= '0;
            r_rptr_gray    <= '0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_count     <= '0;
            r_dvld         <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            r_rbin         <= w_rbin_next;
            r_rptr_gray    <= w_rgray_next;
            r_empty        <= (w_rgray_next == bus.wptr_gray_sync);
            r_almost_empty <= (w_diff <= PW'(AE_THRESH));
            r_rd_count     <= w_diff;
            r_dvld         <= w_rd_fire;
            r_underflow    <= bus.re & r_empty;
        end
    end

    // rptr_gray leaves straight from its flop for the write-domain synchronizer
    assign bus.rptr_gray    = r_rptr_gray;
    assign bus.raddr        = r_rbin[ADDRWIDTH-1:0];
    assign bus.mem_re       = w_rd_fire;
    assign bus.dvld         = r_dvld;
    assign bus.empty        = r_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.rd_count     = r_rd_count;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// Directed self-checking bench for fifo_rd_ptr_ctrl (ADDRWIDTH=3, AE_THRESH=2).
module tb_fifo_rd_ptr_ctrl;
    localparam int unsigned AW = 3;
    localparam int unsigned PW = AW + 1;

    logic clk = 1'b0;
    logic aresetn;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    fifo_rd_ptr_ctrl_if #(.ADDRWIDTH(AW)) bus ();

    fifo_rd_ptr_ctrl #(.ADDRWIDTH(AW), .AE_THRESH(2)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    function automatic logic [PW-1:0] g(input int b);
        logic [PW-1:0] x;
        x = PW'(b);
        return x ^ (x >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".empty"},        32'(bus.empty),        32'd1);
        chk({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'd1);
        chk({tag, ".rd_count"},     32'(bus.rd_count),     32'd0);
        chk({tag, ".rptr_gray"},    32'(bus.rptr_gray),    32'd0);
        chk({tag, ".raddr"},        32'(bus.raddr),        32'd0);
        chk({tag, ".mem_re"},       32'(bus.mem_re),       32'd0);
        chk({tag, ".dvld"},         32'(bus.dvld),         32'd0);
        chk({tag, ".underflow"},    32'(bus.underflow),    32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] step_gray [3];
        logic [PW-1:0] prev;
        int            exp_ae [3];
        int            pulses;
        int            rb;
        int            done;

        // Reset held while inputs toggle
        aresetn = 1'b0;
        bus.re = 1'b0;
        bus.wptr_gray_sync = '0;
        #2;
        for (int i = 0; i < 4; i++) begin
            bus.re = ((i % 2) == 1);
            bus.wptr_gray_sync = PW'(i * 5 + 1);
            tick();
            chk_reset("rst_hold");
        end
        bus.re = 1'b0;
        bus.wptr_gray_sync = '0;
        aresetn = 1'b1;
        tick();
        chk("post_rst.empty", 32'(bus.empty), 32'd1);
        chk("post_rst.count", 32'(bus.rd_count), 32'd0);

        // Count tracking: write pointer binary 1, 2, 3
        step_gray = '{4'h1, 4'h3, 4'h2};
        exp_ae    = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            bus.wptr_gray_sync = step_gray[i];
            tick();
            chk("count.rd_count", 32'(bus.rd_count), 32'(i + 1));
            chk("count.empty", 32'(bus.empty), 32'd0);
            chk("count.almost_empty", 32'(bus.almost_empty), 32'(exp_ae[i]));
            chk("count.rptr_gray", 32'(bus.rptr_gray), 32'd0);
        end

        // Drain from full: 8 accepted reads, then 2 underflows
        bus.wptr_gray_sync = 4'hC;
        tick();
        chk("full.rd_count", 32'(bus.rd_count), 32'd8);
        chk("full.almost_empty", 32'(bus.almost_empty), 32'd0);
        pulses = 0;
        bus.re = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("drain.mem_re", 32'(bus.mem_re), (k < 8) ? 32'd1 : 32'd0);
            if (k < 8) chk("drain.raddr", 32'(bus.raddr), 32'(k));
            pulses += int'(bus.mem_re);
            tick();
            done = (k + 1 < 8) ? k + 1 : 8;
            chk("drain.dvld", 32'(bus.dvld), (k < 8) ? 32'd1 : 32'd0);
            chk("drain.underflow", 32'(bus.underflow), (k >= 8) ? 32'd1 : 32'd0);
            chk("drain.empty", 32'(bus.empty), (k >= 7) ? 32'd1 : 32'd0);
            chk("drain.rptr_gray", 32'(bus.rptr_gray), 32'(g(done)));
            chk("drain.rd_count", 32'(bus.rd_count), 32'(8 - done));
        end
        chk("drain.pulses", 32'(pulses), 32'd8);
        chk("drain.rptr_end", 32'(bus.rptr_gray), 32'hC);
        bus.re = 1'b0;
        tick();
        chk("drain.underflow_clr", 32'(bus.underflow), 32'd0);

        // Three fill/drain passes, pointers wrap past 15
        rb = 8;
        for (int p = 0; p < 3; p++) begin
            bus.wptr_gray_sync = g(rb + 8);
            tick();
            chk("wrap.full_count", 32'(bus.rd_count), 32'd8);
            chk("wrap.full_empty", 32'(bus.empty), 32'd0);
            bus.re = 1'b1;
            for (int k = 0; k < 8; k++) begin
                #1;
                chk("wrap.mem_re", 32'(bus.mem_re), 32'd1);
                chk("wrap.raddr", 32'(bus.raddr), 32'(rb % 8));
                prev = bus.rptr_gray;
                tick();
                rb = (rb + 1) % 16;
                chk("wrap.rptr_gray", 32'(bus.rptr_gray), 32'(g(rb)));
                chk("wrap.one_bit", 32'($countones(prev ^ bus.rptr_gray)), 32'd1);
                chk("wrap.empty", 32'(bus.empty), (k == 7) ? 32'd1 : 32'd0);
                chk("wrap.rd_count", 32'(bus.rd_count), 32'(7 - k));
            end
            bus.re = 1'b0;
            tick();
            chk("wrap.idle_empty", 32'(bus.empty), 32'd1);
            chk("wrap.idle_underflow", 32'(bus.underflow), 32'd0);
        end

        // Last word read while write pointer advances in the same cycle
        bus.wptr_gray_sync = g(1);
        tick();
        chk("simul.count1", 32'(bus.rd_count), 32'd1);
        chk("simul.ae1", 32'(bus.almost_empty), 32'd1);
        bus.re = 1'b1;
        bus.wptr_gray_sync = g(2);
        #1;
        chk("simul.mem_re0", 32'(bus.mem_re), 32'd1);
        chk("simul.raddr0", 32'(bus.raddr), 32'd0);
        tick();
        chk("simul.empty", 32'(bus.empty), 32'd0);
        chk("simul.rd_count", 32'(bus.rd_count), 32'd1);
        chk("simul.dvld", 32'(bus.dvld), 32'd1);
        chk("simul.rptr_gray", 32'(bus.rptr_gray), 32'h1);
        #1;
        chk("simul.mem_re1", 32'(bus.mem_re), 32'd1);
        chk("simul.raddr1", 32'(bus.raddr), 32'd1);
        tick();
        chk("simul.empty_after", 32'(bus.empty), 32'd1);
        chk("simul.rptr_after", 32'(bus.rptr_gray), 32'h3);
        bus.re = 1'b0;

        // Reset asserted during a read burst with 5 words stored
        bus.wptr_gray_sync = g(7);
        tick();
        chk("midrst.count5", 32'(bus.rd_count), 32'd5);
        bus.re = 1'b1;
        tick();
        tick();
        chk("midrst.dvld", 32'(bus.dvld), 32'd1);
        chk("midrst.count3", 32'(bus.rd_count), 32'd3);
        chk("midrst.rptr", 32'(bus.rptr_gray), 32'h6);
        aresetn = 1'b0;
        #1;
        chk_reset("midrst.async");
        tick();
        chk_reset("midrst.held");
        aresetn = 1'b1;
        tick();
        chk("midrst.rel_rptr", 32'(bus.rptr_gray), 32'd0);
        chk("midrst.rel_empty", 32'(bus.empty), 32'd0);
        chk("midrst.rel_count", 32'(bus.rd_count), 32'd7);
        chk("midrst.rel_underflow", 32'(bus.underflow), 32'd1);
        chk("midrst.rel_dvld", 32'(bus.dvld), 32'd0);
        #1;
        chk("midrst.rel_mem_re", 32'(bus.mem_re), 32'd1);
        chk("midrst.rel_raddr", 32'(bus.raddr), 32'd0);
        tick();
        chk("midrst.restart_rptr", 32'(bus.rptr_gray), 32'h1);
        chk("midrst.restart_dvld", 32'(bus.dvld), 32'd1);
        bus.re = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ptr_ctrl.md
# fifo_rd_ptr_ctrl

Read-domain pointer and flag controller for the dual-clock FIFO. It consumes the write pointer after it has crossed into the read clock domain through the double-flop synchronizer. It produces the Gray-coded read pointer that the write side synchronizes back, the RAM read address and enable, and the empty, almost-empty, count and underflow status seen by the FIFO reader.

## Interface
Parameters:
- ADDRWIDTH, 3: RAM address width. Depth = 2^ADDRWIDTH. Pointers are ADDRWIDTH+1 bits.
- AE_THRESH, 2: almost_empty asserts when the stored word count is at or below this value.

Ports:
- clk  in  1  read-domain clock
- aresetn  in  1  reset, asynchronous, active-low
- re  in  1  read request from the FIFO consumer
- wptr_gray_sync  in  ADDRWIDTH+1  Gray write pointer, already double-synchronized into clk
- rptr_gray  out  ADDRWIDTH+1  registered Gray read pointer, sent to the write-domain synchronizer
- raddr  out  ADDRWIDTH  RAM read address (head of queue)
- mem_re  out  1  RAM read enable
- dvld  out  1  read data valid, aligned with the registered RAM output
- empty  out  1  no words available
- almost_empty  out  1  rd_count <= AE_THRESH
- rd_count  out  ADDRWIDTH+1  words stored, 0..2^ADDRWIDTH
- underflow  out  1  one-cycle pulse when a read is requested while empty

## Operation
- rd_fire = re & ~empty. A read is accepted only on rd_fire. re while empty is ignored and flagged.
- rbin_next = rbin + rd_fire, modulo 2^(ADDRWIDTH+1). rgray_next = rbin_next ^ (rbin_next >> 1).
- wbin = Gray-to-binary of wptr_gray_sync, combinational: bit i = XOR of wptr_gray_sync bits ADDRWIDTH down to i.
- diff = (wbin - rbin_next) modulo 2^(ADDRWIDTH+1).
- Registers update on each clk edge as follows:
  - rbin <= rbin_next
  - rptr_gray <= rgray_next
  - empty <= (rgray_next == wptr_gray_sync)
  - rd_count <= diff
  - almost_empty <= (diff <= AE_THRESH)
  - dvld <= rd_fire
  - underflow <= re & empty
- raddr = rbin[ADDRWIDTH-1:0], driven directly from the register.
- mem_re = rd_fire, combinational.
- The block does not use a state machine. Its state is the rbin/rptr_gray pointer pair plus the registered flags.
- rptr_gray is the only signal that crosses domains. It comes straight from a flop with no logic after it, and at most one bit changes per clk.
- A legal upstream never presents diff > 2^ADDRWIDTH. The block neither saturates nor checks this case.

## Timing
- Reset values (asynchronous, immediate on aresetn low):
  - rbin = 0, rptr_gray = 0, rd_count = 0
  - empty = 1, almost_empty = 1
  - dvld = 0, underflow = 0
  - raddr = 0, and mem_re = 0 because empty = 1
- The first edge after aresetn deasserts is a normal update.
- A change on wptr_gray_sync is reflected in empty, rd_count and almost_empty at the next clk edge (1 cycle).
  - End-to-end write-to-not-empty latency is 2 synchronizer cycles plus this 1 cycle.
- Read latency:
  - Cycle N: mem_re high, raddr = head address.
  - Edge N+1: RAM output register captures the word and dvld = 1.
- A read of the last word and a pointer update in the same cycle are both resolved by the same compare. empty stays 0 if wptr_gray_sync has already advanced, and goes 1 otherwise.
- Wrap-around: rbin rolls from 2^(ADDRWIDTH+1)-1 to 0 with no glitch on empty.
  - The MSB distinguishes the full case (diff = 2^ADDRWIDTH) from the empty case (diff = 0).
- Back-to-back reads at one per clk are sustained while empty = 0. The read that empties the FIFO sets empty at the next edge, which blocks any further read.
- Reset asserted mid-burst returns every output to its reset value in the same cycle. mem_re drops combinationally because empty is forced to 1.
  - Any in-flight dvld is discarded.

## Test plan
- Reset behaviour: hold aresetn low and toggle re and wptr_gray_sync.
  - Required: empty = 1, almost_empty = 1, rd_count = 0, rptr_gray = 0, mem_re = 0, dvld = 0, underflow = 0.
- Count tracking: with ADDRWIDTH = 3 and AE_THRESH = 2, step wptr_gray_sync through Gray 1, 3, 2 (binary 1, 2, 3) with re = 0.
  - Required, one cycle after each step: rd_count = 1, 2, 3; empty = 0 from the first step; almost_empty = 1, 1, 0.
- Drain to empty: with the write pointer at 8 (full, Gray 0xC), drive re = 1 for 10 cycles.
  - Required: exactly 8 mem_re pulses with raddr 0..7, dvld delayed by 1, rptr_gray ending at 0xC, empty = 1, and underflow pulses on the last 2 cycles.
- Wrap-around: perform 3 full fill/drain passes of 8 words, so the pointers wrap past 15.
  - Required: raddr sequence 0..7 repeated, one rptr_gray bit changing per read, and no false empty or non-empty at the 15-to-0 wrap.
- Simultaneous event: with 1 word stored, read it in the same cycle that wptr_gray_sync advances by one.
  - Required: empty stays 0, rd_count = 1, and the next read is accepted.
- Reset mid-burst: assert aresetn during a continuous read with 5 words stored.
  - Required: outputs go to their reset values that cycle, and after release rptr_gray restarts at 0.
